// File: rtl/i2s_tx.sv
// i2s_tx -- I2S master transmitter (playback / capture loopback source).
//
// Stereo DATA_W-bit sample pairs arrive on a valid/ready stream and are queued
// in a small FIFO. SCK and WS are generated from clk. Each 64-SCK frame sends
// the left word while WS=0 and the right word while WS=1, MSB first, one bit
// after each WS edge. All serial outputs change on the SCK falling edge.
//
// Ports:
//   clk, rst_n      system clock; synchronous active-low reset
//   en              transmit enable, acted on only at frame boundaries
//   s_valid/s_ready sample-pair stream handshake (s_ready = !full)
//   s_left/s_right  two's complement samples
//   underrun_clr    clears the sticky underrun flag
//   sck, ws, sd     I2S bus (ws=0 selects the left channel)
//   frame_start     one-clk pulse when a frame's data is loaded
//   underrun        sticky: a frame started with the FIFO empty
//   level           FIFO occupancy
//
// Build option I2S_TX_UNDERRUN_HOLD_EN: when defined, an underrun frame
// retransmits the previous frame's samples; otherwise it sends zeros.

module i2s_tx #(
  parameter int CLK_DIV    = 8,   // clk cycles per SCK half-period, >= 2
  parameter int DATA_W     = 24,  // bits per channel, <= 31
  parameter int FIFO_DEPTH = 4    // power of two, >= 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_left,
  input  logic [DATA_W-1:0]             s_right,
  input  logic                          underrun_clr,
  output logic                          sck,
  output logic                          ws,
  output logic                          sd,
  output logic                          frame_start,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Sample-pair FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              full, empty, push, pop;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign s_ready = !full;
  assign push    = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= s_left;
      mem_r[wr_ptr] <= s_right;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / control strobes
  // ---------------------------------------------------------------------------
  logic [CW-1:0] div_cnt;
  logic [5:0]    bit_cnt, bit_nxt;
  logic          tick, fall, wrap, load, go_idle, under_set;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (go_idle) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tick: SCK edge due; fall: that edge is 1->0; wrap: the fall that starts
  // a new frame. en is only looked at on wrap so a frame is never cut short.
  always_comb begin
    tick    = 1'b0;
    fall    = 1'b0;
    wrap    = 1'b0;
    load    = 1'b0;
    go_idle = 1'b0;
    if (state == RUN) begin
      tick    = (div_cnt == DIV_LAST);
      fall    = tick && sck;
      wrap    = fall && (bit_cnt == 6'd63);
      load    = wrap && en;
      go_idle = wrap && !en;
    end
  end

  assign pop       = load && !empty;
  assign under_set = load && empty;
  assign bit_nxt   = bit_cnt + 6'd1;

  // ---------------------------------------------------------------------------
  // Frame sample registers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] left_sh, right_sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      left_sh  <= '0;
      right_sh <= '0;
    end else if (pop) begin
      left_sh  <= mem_l[rd_ptr];
      right_sh <= mem_r[rd_ptr];
    end else if (under_set) begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      // keep the last frame so it is sent again
      left_sh  <= left_sh;
      right_sh <= right_sh;
`else
      left_sh  <= '0;
      right_sh <= '0;
`endif
    end
  end

  // Bit selected for the upcoming slot. Left MSB sits in slot 1, right MSB in
  // slot 33; slot 0, slot 32 and everything past DATA_W in each half are 0.
  // The words are indexed in place rather than shifted so that a hold-mode
  // underrun still has the previous frame intact.
  logic sd_nxt;

  always_comb begin
    sd_nxt = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (bit_nxt == 6'(DATA_W - i))      sd_nxt = left_sh[i];
      if (bit_nxt == 6'(32 + DATA_W - i)) sd_nxt = right_sh[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Serial timing and bus outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= 6'd63;
      sck     <= 1'b0;
      ws      <= 1'b0;
      sd      <= 1'b0;
    end else if (state == IDLE || go_idle) begin
      // bit_cnt parked at 63 so the first fall after RUN wraps to slot 0
      div_cnt <= '0;
      bit_cnt <= 6'd63;
      sck     <= 1'b0;
      ws      <= 1'b0;
      sd      <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sck     <= !sck;
      if (fall) begin
        bit_cnt <= bit_nxt;
        ws      <= bit_nxt[5];
        sd      <= sd_nxt;
      end
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= load;
      // a new underrun outranks a simultaneous clear
      if (under_set)         underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule
